// File: rtl/im_loader.sv
// im_loader: fills the instruction memory from a byte stream.
// Stream format: 16-bit big-endian word count N, then N big-endian 32-bit words.
// After the program words, the rest of IM is zero-filled. The CPU is held
// (cpu_hold=1) until the whole image is in place.
//
// Handshake: a byte moves only on a rising clk edge where byte_valid and
// byte_ready are both high. byte_ready depends only on loader state, never on
// byte_valid. byte_valid may drop at any time, and idle cycles change nothing.
module im_loader #(
    parameter int          ADDR_W  = 12,
    parameter logic [31:0] BASE_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold,
    output logic [31:0]       load_pc,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CLEAR  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    state_t            state;
    state_t            state_next;
    logic [15:0]       n_words;
    // One bit wider than the address, so that a count of DEPTH can be told
    // apart from wrap-around to address 0.
    logic [ADDR_W:0]   wptr;
    logic [23:0]       partial;   // first three bytes of the word being assembled
    logic [1:0]        bcnt;
    logic              accept;
    logic              start_ok;
    logic              wptr_at_n;
    logic              wptr_at_end;
    logic [15:0]       len_full;

    assign accept      = byte_valid & byte_ready;
    assign start_ok    = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
    assign len_full    = {n_words[15:8], byte_data};
    assign wptr_at_n   = (32'(wptr) == 32'(n_words));
    assign wptr_at_end = (32'(wptr) == DEPTH);
    assign load_pc     = BASE_PC;
    assign state_dbg   = state;

    // Status outputs decoded from state. In DATA, byte_ready drops once every
    // word has been issued, so no byte after the image is consumed.
    always_comb begin
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_hold   = 1'b1;
        case (state)
            S_LEN_HI: begin byte_ready = 1'b1; busy = 1'b1; end
            S_LEN_LO: begin byte_ready = 1'b1; busy = 1'b1; end
            S_DATA:   begin byte_ready = ~wptr_at_n; busy = 1'b1; end
            S_CLEAR:  busy = 1'b1;
            S_DONE:   begin done = 1'b1; cpu_hold = 1'b0; end
            S_ERR:    error = 1'b1;
            default:  ;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_next = S_LEN_HI;
            S_LEN_HI: if (accept) state_next = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if (32'(len_full) > DEPTH)   state_next = S_ERR;
                    else if (len_full == 16'd0)  state_next = S_CLEAR;
                    else                         state_next = S_DATA;
                end
            end
            // Leave DATA in the cycle that shows the last word write.
            S_DATA: begin
                if (wptr_at_n) state_next = (32'(n_words) == DEPTH) ? S_DONE : S_CLEAR;
            end
            // Leave CLEAR in the cycle that shows the write of the top address.
            S_CLEAR: if (wptr_at_end) state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Datapath: length capture, word assembly, and registered IM write port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_words  <= 16'd0;
            wptr     <= '0;
            partial  <= 24'd0;
            bcnt     <= 2'd0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= 32'd0;
        end else begin
            im_we <= 1'b0;
            if (start_ok) begin
                n_words <= 16'd0;
                wptr    <= '0;
                partial <= 24'd0;
                bcnt    <= 2'd0;
            end else begin
                case (state)
                    S_LEN_HI: if (accept) n_words[15:8] <= byte_data;
                    S_LEN_LO: if (accept) n_words[7:0]  <= byte_data;
                    S_DATA: begin
                        if (accept) begin
                            partial <= {partial[15:0], byte_data};
                            bcnt    <= bcnt + 2'd1;
                            if (bcnt == 2'd3) begin
                                im_we    <= 1'b1;
                                im_addr  <= wptr[ADDR_W-1:0];
                                im_wdata <= {partial, byte_data};
                                wptr     <= wptr + 1'b1;
                            end
                        end
                    end
                    S_CLEAR: begin
                        if (!wptr_at_end) begin
                            im_we    <= 1'b1;
                            im_addr  <= wptr[ADDR_W-1:0];
                            im_wdata <= 32'd0;
                            wptr     <= wptr + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Testbench for im_loader: directed streams, with a write scoreboard checked by
// an independent monitor.
module tb_im_loader;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        im_we;
    logic [11:0] im_addr;
    logic [31:0] im_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;
    logic [31:0] load_pc;
    logic [2:0]  state_dbg;

    im_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_hold   (cpu_hold),
        .load_pc    (load_pc),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [43:0] exp_q[$];     // {addr, data} of each expected IM write
    logic [31:0] tx_q[$];      // program words of the stream being sent
    logic [43:0] exp_e;
    int          wr_cyc[$];
    bit          log_cyc = 1'b0;
    int          acc_cnt = 0;
    int          t_start = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s", name);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (byte_valid === 1'b1 && byte_ready === 1'b1) acc_cnt++;
        if (im_we === 1'b1) begin
            if (log_cyc) wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                         im_addr, im_wdata);
            end else begin
                exp_e = exp_q.pop_front();
                chk("im_write", {20'd0, im_addr, im_wdata}, {20'd0, exp_e});
            end
        end
    end

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic pulse_start();
        start   = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gappy, input bit kick);
        int  guard;
        int  gaps;
        bit  acc;
        guard = 0;
        gaps  = 0;
        acc   = 1'b0;
        if (gappy) begin
            while ($urandom_range(0, 2) == 0 && gaps < 4) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom_range(0, 255));
                gaps++;
                @(negedge clk);
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        if (kick) start = 1'b1;
        while (!acc && guard < 50) begin
            acc = byte_ready;
            @(negedge clk);
            start = 1'b0;
            guard++;
        end
        if (!acc) fail_now("byte_accept_timeout");
    endtask

    task automatic run_stream(input logic [15:0] hdr, input bit gappy, input int kick_at);
        int          idx;
        logic [31:0] w;
        idx = 0;
        pulse_start();
        send_byte(hdr[15:8], gappy, 1'b0);
        send_byte(hdr[7:0], gappy, 1'b0);
        foreach (tx_q[i]) begin
            w = tx_q[i];
            for (int j = 3; j >= 0; j--) begin
                send_byte(w[8*j +: 8], gappy, idx == kick_at);
                idx++;
            end
        end
        byte_valid = 1'b0;
    endtask

    // Expected writes for an n-word image: program words, then zero fill.
    task automatic push_image(input int n);
        for (int i = 0; i < DEPTH; i++) begin
            if (i < n) exp_q.push_back({12'(i), tx_q[i]});
            else       exp_q.push_back({12'(i), 32'd0});
        end
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_reached", {63'd0, done}, 64'd1);
    endtask

    task automatic check_done_state(input string tag);
        chk({tag, "_cpu_hold"}, {63'd0, cpu_hold}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_load_pc"}, {32'd0, load_pc}, 64'h3000);
        chk({tag, "_all_writes"}, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_byte_ready", {63'd0, byte_ready}, 64'd0);
        chk("rst_im_we", {63'd0, im_we}, 64'd0);
        chk("rst_im_addr", {52'd0, im_addr}, 64'd0);
        chk("rst_im_wdata", {32'd0, im_wdata}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        reset = 1'b1;
        @(negedge clk);

        // Two words, continuous valid: latency and back-to-back timing
        tx_q = '{32'h2401_0005, 32'h0000_000C};
        push_image(2);
        wr_cyc.delete();
        log_cyc = 1'b1;
        run_stream(16'h0002, 1'b0, -1);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_cpu_hold_loading", {63'd0, cpu_hold}, 64'd1);
        wait_done(5000);
        log_cyc = 1'b0;
        check_done_state("t1");
        chk("t1_write_count", 64'(wr_cyc.size()), 64'(DEPTH));
        if (wr_cyc.size() >= 2) begin
            chk("t1_first_write_latency", 64'(wr_cyc[0] - t_start), 64'd7);
            chk("t1_word_spacing", 64'(wr_cyc[1] - wr_cyc[0]), 64'd4);
        end

        // Empty image: no bytes taken after the header
        tx_q.delete();
        push_image(0);
        run_stream(16'h0000, 1'b0, -1);
        acc_cnt    = 0;
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        wait_done(5000);
        byte_valid = 1'b0;
        chk("t2_bytes_after_header", 64'(acc_cnt), 64'd0);
        check_done_state("t2");

        // Full image: no clear writes, no wrap
        tx_q.delete();
        for (int i = 0; i < DEPTH; i++) tx_q.push_back(32'hC0DE_0000 | 32'(i));
        push_image(DEPTH);
        run_stream(16'h1000, 1'b0, -1);
        wait_done(100);
        check_done_state("t3");
        repeat (4) @(negedge clk);

        // Oversized header: error, then recovery
        tx_q.delete();
        run_stream(16'h1001, 1'b0, -1);
        acc_cnt    = 0;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (20) @(negedge clk);
        chk("t4_error", {63'd0, error}, 64'd1);
        chk("t4_byte_ready", {63'd0, byte_ready}, 64'd0);
        chk("t4_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        chk("t4_busy", {63'd0, busy}, 64'd0);
        chk("t4_done", {63'd0, done}, 64'd0);
        chk("t4_bytes_in_err", 64'(acc_cnt), 64'd0);
        byte_valid = 1'b0;
        tx_q = '{32'hDEAD_BEEF};
        push_image(1);
        run_stream(16'h0001, 1'b0, -1);
        wait_done(5000);
        chk("t4_error_cleared", {63'd0, error}, 64'd0);
        check_done_state("t4");

        // Gappy valid with a start pulse in mid-DATA
        tx_q = '{32'h2401_0005, 32'h0000_000C};
        push_image(2);
        run_stream(16'h0002, 1'b1, 5);
        wait_done(5000);
        check_done_state("t5");

        // Asynchronous reset after word 0 and two bytes of word 1
        exp_q.push_back({12'd0, 32'h2401_0005});
        pulse_start();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h24, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        byte_valid = 1'b0;
        chk("t6_busy_before_reset", {63'd0, busy}, 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_byte_ready", {63'd0, byte_ready}, 64'd0);
        chk("t6_rst_im_we", {63'd0, im_we}, 64'd0);
        chk("t6_rst_im_addr", {52'd0, im_addr}, 64'd0);
        chk("t6_rst_im_wdata", {32'd0, im_wdata}, 64'd0);
        chk("t6_rst_busy", {63'd0, busy}, 64'd0);
        chk("t6_rst_done", {63'd0, done}, 64'd0);
        chk("t6_rst_error", {63'd0, error}, 64'd0);
        chk("t6_rst_cpu_hold", {63'd0, cpu_hold}, 64'd1);
        chk("t6_word0_seen", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push_image(2);
        run_stream(16'h0002, 1'b0, -1);
        wait_done(5000);
        check_done_state("t6");

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads combinationally by PC.
- Receives a byte stream (header plus program words) over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes the words into IM word addresses 0.., then zero-fills the rest of IM.
- Holds the CPU (cpu_hold) until the image is complete.

Parameters:
- ADDR_W, 12, IM word-address width; depth = 2^ADDR_W words (4096).
- BASE_PC, 32'h0000_3000, byte address of IM word 0; reported on load_pc only.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- byte_valid  in  1  upstream byte present.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_data this cycle.
- im_we  out  1  IM write strobe, one word per cycle.
- im_addr  out  ADDR_W  IM word address.
- im_wdata  out  32  IM write data.
- busy  out  1  load in progress.
- done  out  1  image complete; held until next start.
- error  out  1  header word count > depth; held until next start.
- cpu_hold  out  1  keep CPU/PC frozen while high.
- load_pc  out  32  BASE_PC; valid when done=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - Outputs low: byte_ready, im_we, im_addr, im_wdata, busy, done, error.
  - cpu_hold=1.
  - Internal counters and the partial word are cleared.
  - Reset during any state aborts the load; IM contents are then undefined.
- Handshake:
  - A byte is consumed only on a rising edge with byte_valid & byte_ready.
  - byte_ready=1 only in LEN_HI, LEN_LO and DATA.
  - byte_valid may drop at any time; gaps do not alter state.
- States:
  - IDLE: start -> LEN_HI, busy=1, done=0, error=0. Other inputs are ignored.
  - LEN_HI: accept byte -> N[15:8], go to LEN_LO.
  - LEN_LO: accept byte -> N[7:0], then:
    - N > 2^ADDR_W -> ERR.
    - N == 0 -> CLEAR with wptr=0.
    - otherwise -> DATA.
  - DATA:
    - Bytes shift into a 32-bit assembly register; the first byte goes to [31:24].
    - On the 4th byte of a word: the next cycle has im_we=1, im_addr=wptr, im_wdata=word, and wptr increments.
    - byte_ready stays high during that write cycle, so back-to-back words run at 4 cycles/word with no bubble.
    - After writing word N-1:
      - N == 2^ADDR_W -> DONE.
      - else -> CLEAR.
  - CLEAR:
    - byte_ready=0.
    - Each cycle: im_we=1, im_addr=wptr, im_wdata=0, wptr++.
    - After writing address 2^ADDR_W-1 -> DONE.
  - DONE: busy=0, done=1, cpu_hold=0. start -> LEN_HI (re-load; cpu_hold=1 again, done=0).
  - ERR: busy=0, error=1, cpu_hold=1, no IM writes. start -> LEN_HI.
- Outputs:
  - im_we, im_addr and im_wdata are registered; im_we=0 in all cycles not listed above.
  - wptr is ADDR_W+1 bits so that N=4096 is distinguished from wrap-around; im_addr = wptr[ADDR_W-1:0].
  - cpu_hold = 1 in every state except DONE.
  - start while busy=1 is ignored.
- Latency: with continuous byte_valid, N>0 and start at cycle 0, the first im_we occurs in cycle 7.

Test Plan:
- Header 0x0002, then bytes 24 01 00 05 / 00 00 00 0C, continuous valid:
  - Writes IM[0]=0x24010005 and IM[1]=0x0000000C.
  - Then IM[2..4095] are written with 0.
  - Then done=1, cpu_hold=0, load_pc=0x00003000.
- Header 0x0000:
  - No bytes are accepted after the header; 4096 zero writes occur, then done.
- Header 0x1000 with 4096 words:
  - No CLEAR writes; done is set after the IM[4095] write.
  - No address wrap: IM[0] is not rewritten.
- Header 0x1001:
  - error=1, zero im_we pulses, byte_ready=0, cpu_hold=1.
  - A subsequent start plus header 0x0001 and word 0xDEADBEEF recovers: IM[0]=0xDEADBEEF, then done.
- Same stream as the first case with byte_valid toggled randomly:
  - Identical IM writes and values, only delayed.
  - A start pulse mid-DATA has no effect.
- reset=0 asserted after 2 bytes of word 1:
  - Outputs return to reset values immediately (asynchronously).
  - A new start and full stream completes correctly, with no leftover partial-word bytes.
